// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - WB_SEL_* : result format select codes carried with each result.
//   - wb_entry_t : buffered-result layout {dest, wen_eff, data} for the
//     default configuration (16-bit data, 5-bit register address).
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_LBS = 2'b01;
  localparam logic [1:0] WB_SEL_LBU = 2'b10;
  localparam logic [1:0] WB_SEL_LW  = 2'b11;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] dest;
    logic                 wen;   // already cleared for r0
    logic [WB_DATA_W-1:0] data;  // already formatted
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small in-order result buffer for the write-back stage.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_*          enqueue one formatted result
//   pop, head_*           dequeue / current oldest entry
//   count                 number of buffered entries
//   ent_vld/ent_wen/ent_dest  per-slot view used by the hazard compare
// Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [AW-1:0]             push_dest,
  input  logic                      push_wen,
  input  logic [DW-1:0]             push_data,
  input  logic                      pop,
  output logic [AW-1:0]             head_dest,
  output logic                      head_wen,
  output logic [DW-1:0]             head_data,
  output logic [CW-1:0]             count,
  output logic [DEPTH-1:0]          ent_vld,
  output logic [DEPTH-1:0]          ent_wen,
  output logic [DEPTH-1:0][AW-1:0]  ent_dest
);

  typedef struct packed {
    logic [AW-1:0] dest;
    logic          wen;
    logic [DW-1:0] data;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        vld_q[rd_ptr] <= 1'b0;
      end
      // A push never lands on the slot being popped (full blocks push).
      if (push) begin
        mem[wr_ptr]   <= '{dest: push_dest, wen: push_wen, data: push_data};
        wr_ptr        <= wr_ptr + 1'b1;
        vld_q[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_dest = mem[rd_ptr].dest;
  assign head_wen  = mem[rd_ptr].wen;
  assign head_data = mem[rd_ptr].data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_vld[i]  = vld_q[i];
    assign ent_wen[i]  = mem[i].wen;
    assign ent_dest[i] = mem[i].dest;
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage, sole driver of the register-file
// write port.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           result handshake from the memory stage
//   in_dest/in_wen/in_sel/in_byte/in_alu/in_mem  result fields
//   stall                       freeze: no write issued this cycle
//   w_data/w_addr/w_ena         registered register-file write port
//   q1_addr/q2_addr, q1_busy/q2_busy  decode read-address hazard query
// Results are formatted on accept. With an empty buffer the accepted input
// issues straight through; otherwise the buffer head issues and the input
// is queued behind it, so order is preserved.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_dest,
  input  logic                  in_wen,
  input  logic [1:0]            in_sel,
  input  logic                  in_byte,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_mem,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_ena,
  input  logic [ADDR_WIDTH-1:0] q1_addr,
  input  logic [ADDR_WIDTH-1:0] q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // format
  logic [7:0]            byte_v;
  logic [DATA_WIDTH-1:0] in_fmt;
  logic                  in_wen_eff;

  always_comb begin
    byte_v = in_byte ? in_mem[15:8] : in_mem[7:0];
    case (in_sel)
      WB_SEL_LBS: in_fmt = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      WB_SEL_LBU: in_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      WB_SEL_LW:  in_fmt = in_mem;
      default:    in_fmt = in_alu;
    endcase
  end

  assign in_wen_eff = in_wen && (in_dest != '0);

  // buffer + issue
  logic [CW-1:0]                      count;
  logic [ADDR_WIDTH-1:0]              head_dest;
  logic                               head_wen;
  logic [DATA_WIDTH-1:0]              head_data;
  logic [FIFO_DEPTH-1:0]              ent_vld, ent_wen;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] ent_dest;
  logic empty, accept, issue, push, pop;
  logic [ADDR_WIDTH-1:0] src_dest;
  logic                  src_wen;
  logic [DATA_WIDTH-1:0] src_data;

  assign in_ready = (count != FULL);
  assign empty    = (count == '0);
  assign accept   = in_valid && in_ready;
  assign issue    = !stall && (!empty || accept);
  assign pop      = issue && !empty;
  assign push     = accept && !(issue && empty);   // bypass skips the buffer

  assign src_dest = empty ? in_dest    : head_dest;
  assign src_wen  = empty ? in_wen_eff : head_wen;
  assign src_data = empty ? in_fmt     : head_data;

  wb_fifo #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_dest (in_dest),
    .push_wen  (in_wen_eff),
    .push_data (in_fmt),
    .pop       (pop),
    .head_dest (head_dest),
    .head_wen  (head_wen),
    .head_data (head_data),
    .count     (count),
    .ent_vld   (ent_vld),
    .ent_wen   (ent_wen),
    .ent_dest  (ent_dest)
  );

  // write port
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ena  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (issue) begin
      w_ena  <= src_wen;
      w_addr <= src_dest;
      w_data <= src_data;
    end else begin
      w_ena  <= 1'b0;
    end
  end

  // hazard query: in-flight = buffered entries plus the write on the port
  logic [1:0][ADDR_WIDTH-1:0] q_addr;
  logic [1:0]                 q_busy;

  assign q_addr = {q2_addr, q1_addr};

  for (genvar p = 0; p < 2; p++) begin : g_q
    logic hit;
    always_comb begin
      hit = w_ena && (w_addr == q_addr[p]);
      for (int e = 0; e < FIFO_DEPTH; e++)
        if (ent_vld[e] && ent_wen[e] && (ent_dest[e] == q_addr[p])) hit = 1'b1;
    end
    assign q_busy[p] = hit && (q_addr[p] != '0);
  end

  assign q1_busy = q_busy[0];
  assign q2_busy = q_busy[1];

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios followed by random traffic, all checked
// every cycle against a queue-based model of the stage.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_wen = 1'b0, in_byte = 1'b0, stall = 1'b0;
  logic [AW-1:0] in_dest = '0, q1_addr = '0, q2_addr = '0;
  logic [1:0]    in_sel = '0;
  logic [DW-1:0] in_alu = '0, in_mem = '0;
  logic          in_ready, w_ena, q1_busy, q2_busy;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  wb_entry_t     mq[$];
  logic          m_wena  = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_wen(in_wen), .in_sel(in_sel), .in_byte(in_byte),
    .in_alu(in_alu), .in_mem(in_mem), .stall(stall),
    .w_data(w_data), .w_addr(w_addr), .w_ena(w_ena),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fmt(input logic [1:0] sel, input logic byt,
                                        input logic [DW-1:0] alu, input logic [DW-1:0] mem);
    int m, b;
    m = int'(mem);
    b = byt ? (m / 256) % 256 : m % 256;
    case (sel)
      2'd1:    return DW'(b >= 128 ? b + 'hFF00 : b);
      2'd2:    return DW'(b);
      2'd3:    return mem;
      default: return alu;
    endcase
  endfunction

  function automatic logic mbusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (m_wena && m_waddr == a) return 1'b1;
    foreach (mq[i]) if (mq[i].wen && mq[i].dest == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check DUT against model mid-cycle, then advance the model.
  task automatic cyc();
    wb_entry_t e;
    @(negedge clk); #1;
    chk("w_ena",    w_ena,    m_wena);
    chk("w_addr",   w_addr,   m_waddr);
    chk("w_data",   w_data,   m_wdata);
    chk("in_ready", in_ready, mq.size() != DEPTH);
    chk("q1_busy",  q1_busy,  mbusy(q1_addr));
    chk("q2_busy",  q2_busy,  mbusy(q2_addr));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_wena = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (in_valid && mq.size() < DEPTH)
        mq.push_back('{dest: in_dest, wen: in_wen && in_dest != 0,
                       data: fmt(in_sel, in_byte, in_alu, in_mem)});
      if (!stall && mq.size() > 0) begin
        e = mq.pop_front();
        m_wena = e.wen; m_waddr = e.dest; m_wdata = e.data;
      end else begin
        m_wena = 1'b0;
      end
    end
    #1;
  endtask

  task automatic send(input logic [AW-1:0] d, input logic wen, input logic [1:0] sel,
                      input logic byt, input logic [DW-1:0] alu, input logic [DW-1:0] mem);
    in_valid = 1'b1; in_dest = d; in_wen = wen; in_sel = sel;
    in_byte = byt; in_alu = alu; in_mem = mem;
  endtask

  task automatic peek(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk({tag, "_ena"},  w_ena,  1'b1);
    chk({tag, "_addr"}, w_addr, a);
    chk({tag, "_data"}, w_data, d);
  endtask

  initial begin
    // reset with a valid result offered: nothing may be accepted
    send(5'd7, 1'b1, WB_SEL_ALU, 1'b0, 16'h5555, 16'h0);
    @(posedge clk); #1;
    cyc(); cyc();
    chk("rst_ena",   w_ena,    1'b0);
    chk("rst_data",  w_data,   16'h0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0;
    cyc();

    // ALU stream, one per cycle, visible one edge after accept
    send(5'd3, 1'b1, WB_SEL_ALU, 1'b0, 16'h1111, 16'h0); cyc(); peek("alu3", 5'd3, 16'h1111);
    send(5'd4, 1'b1, WB_SEL_ALU, 1'b0, 16'h2222, 16'h0); cyc(); peek("alu4", 5'd4, 16'h2222);
    send(5'd5, 1'b1, WB_SEL_ALU, 1'b0, 16'h3333, 16'h0); cyc(); peek("alu5", 5'd5, 16'h3333);

    // load formatting
    send(5'd10, 1'b1, WB_SEL_LBS, 1'b0, 16'h0, 16'h80F7); cyc(); peek("lbs0", 5'd10, 16'hFFF7);
    send(5'd11, 1'b1, WB_SEL_LBU, 1'b1, 16'h0, 16'h80F7); cyc(); peek("lbu1", 5'd11, 16'h0080);
    send(5'd12, 1'b1, WB_SEL_LBS, 1'b1, 16'h0, 16'h80F7); cyc(); peek("lbs1", 5'd12, 16'hFF80);
    send(5'd13, 1'b1, WB_SEL_LW,  1'b0, 16'h0, 16'h80F7); cyc(); peek("lw",   5'd13, 16'h80F7);

    // write to r0 takes a slot but never pulses
    send(5'd0, 1'b1, WB_SEL_ALU, 1'b0, 16'hABCD, 16'h0); cyc(); chk("r0_ena", w_ena, 1'b0);
    in_valid = 1'b0; cyc();

    // stall and backpressure
    stall = 1'b1;
    send(5'd6, 1'b1, WB_SEL_ALU, 1'b0, 16'h0606, 16'h0); cyc();
    send(5'd7, 1'b1, WB_SEL_ALU, 1'b0, 16'h0707, 16'h0); cyc();
    chk("bp_ready", in_ready, 1'b0);
    send(5'd8, 1'b1, WB_SEL_ALU, 1'b0, 16'h0808, 16'h0); cyc(); cyc();
    chk("bp_stall_ena", w_ena, 1'b0);
    stall = 1'b0;
    cyc(); peek("bp6", 5'd6, 16'h0606);
    cyc(); peek("bp7", 5'd7, 16'h0707);
    in_valid = 1'b0;
    cyc(); peek("bp8", 5'd8, 16'h0808);

    // hazard on a buffered write
    stall = 1'b1; q1_addr = 5'd9; q2_addr = 5'd0;
    send(5'd9, 1'b1, WB_SEL_ALU, 1'b0, 16'h0909, 16'h0); cyc();
    in_valid = 1'b0; cyc();
    chk("haz_q1", q1_busy, 1'b1);
    chk("haz_q2", q2_busy, 1'b0);
    stall = 1'b0;
    cyc(); peek("haz9", 5'd9, 16'h0909);
    chk("haz_q1_pulse", q1_busy, 1'b1);
    cyc(); chk("haz_drop", q1_busy, 1'b0);

    // reset while two results are buffered
    stall = 1'b1; q1_addr = 5'd14; q2_addr = 5'd15;
    send(5'd14, 1'b1, WB_SEL_ALU, 1'b0, 16'h1414, 16'h0); cyc();
    send(5'd15, 1'b1, WB_SEL_ALU, 1'b0, 16'h1515, 16'h0); cyc();
    chk("rs_q1_pre", q1_busy, 1'b1);
    in_valid = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; stall = 1'b0;
    chk("rs_q1", q1_busy, 1'b0);
    chk("rs_q2", q2_busy, 1'b0);
    chk("rs_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("rs_nowr", w_ena, 1'b0);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      in_dest  = AW'($urandom_range(0, 15));
      in_wen   = ($urandom_range(0, 99) < 85);
      in_sel   = 2'($urandom_range(0, 3));
      in_byte  = 1'($urandom_range(0, 1));
      in_alu   = DW'($urandom);
      in_mem   = DW'($urandom);
      stall    = ($urandom_range(0, 99) < 30);
      rst      = ($urandom_range(0, 199) == 0);
      q1_addr  = AW'($urandom_range(0, 15));
      q2_addr  = AW'($urandom_range(0, 15));
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; stall = 1'b0;
    cyc(); cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
